vga_line_buffer: RTL and testbench

//  Ping-pong line buffer upstream of the 800x600@60Hz VGA output stage. Pixel producer writes
//  one line into a fill bank over a valid/ready handshake. On each visible-line start from the

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_lb_bank.sv | 26 ++
 rtl/vga_line_buffer.sv | 161 ++++++++++++++++
 tb/tb_vga_line_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants, pixel type and the colour-bar lookup for vga_line_buffer.
package vga_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 600;
   localparam int H_TOTAL  = 1056;
   localparam int V_TOTAL  = 628;
   localparam int ADDR_W   = 10;
   localparam int PIX_W    = 3;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   typedef enum logic {
      WR_FILL = 1'b0,
      WR_WAIT = 1'b1
   } wr_state_e;

   // Bars run black, red, yellow, green, cyan, blue, magenta, white.
   function automatic rgb_t bar_color(input logic [2:0] idx);
      rgb_t c;
      case (idx)
         3'd0:    c = rgb_t'(3'b000);
         3'd1:    c = rgb_t'(3'b100);
         3'd2:    c = rgb_t'(3'b110);
         3'd3:    c = rgb_t'(3'b010);
         3'd4:    c = rgb_t'(3'b011);
         3'd5:    c = rgb_t'(3'b001);
         3'd6:    c = rgb_t'(3'b101);
         default: c = rgb_t'(3'b111);
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_lb_bank.sv
// One line bank: write port plus a registered read port, data appears one cycle after raddr_i.
module vga_lb_bank #(
   parameter int ADDR_W = 10,
   parameter int PIX_W  = 3
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [PIX_W-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [PIX_W-1:0]  rdata_o
);

   logic [PIX_W-1:0] mem_q [2**ADDR_W];
   logic [PIX_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: producer fills one bank while the other is scanned, 1-cycle read latency,
// s_ready low while a closed line waits for line_start. VGA_LB_TEST_PATTERN_EN shows bars on underrun.
module vga_line_buffer #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int ADDR_W   = vga_pkg::ADDR_W,
   parameter int PIX_W    = vga_pkg::PIX_W
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_eol,
   input  logic             frame_start,
   input  logic             line_start,
   input  logic [11:0]      h_cnt,
   input  logic             de,
   output logic             vga_r,
   output logic             vga_g,
   output logic             vga_b,
   output logic             underrun
);

   import vga_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_ACTIVE - 1);

   wr_state_e         state_q, state_d;
   logic              wsel_q, wsel_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W:0]   len_q [2];
   logic [ADDR_W:0]   len_d [2];
   logic [1:0]        full_q, full_d;
   logic              underrun_q, underrun_d;
   logic              vld_q, vld_d;
   logic              rbank_q;
   logic              beat, close, swap, rsel;
   logic [PIX_W-1:0]  rdata0, rdata1, rdata;
   rgb_t              pix;

   // The read bank is always the one not being filled.
   assign rsel  = ~wsel_q;
   assign beat  = s_valid & s_ready & ~frame_start;
   assign close = beat & (s_eol | (wptr_q == LAST_IDX));
   assign swap  = line_start & ((state_q == WR_WAIT) | close);

   always_ff @(posedge clk_sys) begin
      if (rst) state_q <= WR_FILL;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (frame_start || swap) state_d = WR_FILL;
      else if (close)          state_d = WR_WAIT;
   end

   always_comb begin
      s_ready = (state_q == WR_FILL) & ~rst;
   end

   always_comb begin
      wsel_d     = wsel_q;
      wptr_d     = wptr_q;
      len_d      = len_q;
      full_d     = full_q;
      underrun_d = underrun_q;
      if (frame_start) begin
         wptr_d = '0;
         full_d = '0;
      end else begin
         if (beat) wptr_d = wptr_q + 1'b1;
         if (close) begin
            len_d[wsel_q]  = {1'b0, wptr_q} + 1'b1;
            full_d[wsel_q] = 1'b1;
         end
         if (swap) begin
            wsel_d        = ~wsel_q;
            wptr_d        = '0;
            full_d[rsel]  = 1'b0;
         end else if (line_start) begin
            underrun_d   = 1'b1;
            full_d[rsel] = 1'b0;
         end
      end
   end

   always_comb begin
      vld_d = de & full_q[rsel] & (h_cnt < 12'(len_q[rsel]));
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wsel_q     <= 1'b0;
         wptr_q     <= '0;
         len_q[0]   <= '0;
         len_q[1]   <= '0;
         full_q     <= '0;
         underrun_q <= 1'b0;
         vld_q      <= 1'b0;
         rbank_q    <= 1'b0;
      end else begin
         wsel_q     <= wsel_d;
         wptr_q     <= wptr_d;
         len_q      <= len_d;
         full_q     <= full_d;
         underrun_q <= underrun_d;
         vld_q      <= vld_d;
         rbank_q    <= rsel;
      end
   end

   vga_lb_bank #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_bank0 (
      .clk_i   (clk_sys),
      .we_i    (beat & ~wsel_q),
      .waddr_i (wptr_q),
      .wdata_i (s_data),
      .raddr_i (h_cnt[ADDR_W-1:0]),
      .rdata_o (rdata0)
   );

   vga_lb_bank #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_bank1 (
      .clk_i   (clk_sys),
      .we_i    (beat & wsel_q),
      .waddr_i (wptr_q),
      .wdata_i (s_data),
      .raddr_i (h_cnt[ADDR_W-1:0]),
      .rdata_o (rdata1)
   );

   assign rdata = rbank_q ? rdata1 : rdata0;

`ifdef VGA_LB_TEST_PATTERN_EN
   logic pat_vld_q;
   rgb_t pat_q;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         pat_vld_q <= 1'b0;
         pat_q     <= '0;
      end else begin
         pat_vld_q <= de & ~full_q[rsel] & (h_cnt < 12'(H_ACTIVE));
         pat_q     <= bar_color(3'(h_cnt / 12'd100));
      end
   end

   always_comb begin
      pix = vld_q ? rgb_t'(rdata) : (pat_vld_q ? pat_q : '0);
   end
`else
   always_comb begin
      pix = vld_q ? rgb_t'(rdata) : '0;
   end
`endif

   assign vga_r    = pix.r;
   assign vga_g    = pix.g;
   assign vga_b    = pix.b;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Bench for vga_line_buffer: table-driven line tests, hand-written corner sequences, random traffic vs a queue model.
module tb_vga_line_buffer;

   logic        clk_sys = 1'b0;
   logic        rst, s_valid, s_ready, s_eol, frame_start, line_start, de;
   logic        vga_r, vga_g, vga_b, underrun;
   logic [2:0]  s_data;
   logic [11:0] h_cnt;

   always #5 clk_sys = ~clk_sys;

   vga_line_buffer dut (
      .clk_sys     (clk_sys),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_eol       (s_eol),
      .frame_start (frame_start),
      .line_start  (line_start),
      .h_cnt       (h_cnt),
      .de          (de),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .underrun    (underrun)
   );

   typedef struct {
      int         len;
      logic [2:0] color;
      bit         eol;
      int         probe;
      logic [2:0] exp;
   } vec_t;

   vec_t       vecs [8];
   int         n_pass  = 0;
   int         n_total = 0;
   logic [2:0] m_fill [$];
   logic [2:0] m_disp [$];
   bit         m_complete = 0, m_disp_vld = 0, m_underrun = 0;
   logic [2:0] bars [8] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1, 3'd5, 3'd7};
   logic [2:0] scan_out [800];
   bit         last_acc;
   logic [2:0] pat150, pat250;

   task automatic chk(input string name, input int got, input int want);
      n_total++;
      if (got == want) n_pass++;
      else $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, got, want);
   endtask

   // Colour the spec demands one cycle after the current inputs, from the model's pre-update view.
   function automatic logic [2:0] m_expect();
      int h;
      h = int'(h_cnt);
      if (rst || !de) return 3'd0;
      if (m_disp_vld) return (h < m_disp.size()) ? m_disp[h] : 3'd0;
`ifdef VGA_LB_TEST_PATTERN_EN
      if (h < 800) return bars[h / 100];
`endif
      return 3'd0;
   endfunction

   task automatic m_update(input bit beat);
      if (rst) begin
         m_fill.delete(); m_disp.delete();
         m_complete = 0; m_disp_vld = 0; m_underrun = 0;
         return;
      end
      if (frame_start) begin
         m_fill.delete();
         m_complete = 0; m_disp_vld = 0;
         return;
      end
      if (beat) begin
         m_fill.push_back(s_data);
         if (s_eol || m_fill.size() == 800) m_complete = 1;
      end
      if (line_start) begin
         if (m_complete) begin
            m_disp = m_fill; m_disp_vld = 1; m_fill.delete(); m_complete = 0;
         end else begin
            m_underrun = 1; m_disp_vld = 0;
         end
      end
   endtask

   task automatic step();
      bit exp_rdy;
      logic [2:0] exp_pix;
      #1;
      exp_rdy  = !rst && !m_complete;
      chk("s_ready", s_ready, exp_rdy);
      exp_pix  = m_expect();
      last_acc = s_valid && s_ready && !frame_start;
      m_update(s_valid && exp_rdy && !frame_start);
      @(posedge clk_sys); #1;
      chk("rgb", {vga_r, vga_g, vga_b}, exp_pix);
      chk("underrun", underrun, m_underrun);
   endtask

   task automatic idle();
      s_valid = 0; s_eol = 0; s_data = 3'd0;
      frame_start = 0; line_start = 0; de = 0; h_cnt = 12'd900;
   endtask

   task automatic fill(input int n, input logic [2:0] color, input bit eol);
      for (int i = 0; i < n; i++) begin
         s_valid = 1; s_data = color; s_eol = eol && (i == n - 1);
         step();
      end
      s_valid = 0; s_eol = 0;
   endtask

   task automatic scan(input bit with_ls);
      if (with_ls) begin
         line_start = 1; step(); line_start = 0;
      end
      for (int h = 0; h < 800; h++) begin
         de = 1; h_cnt = 12'(h); step();
         scan_out[h] = {vga_r, vga_g, vga_b};
      end
      de = 0; h_cnt = 12'd800;
      repeat (4) step();
   endtask

   initial begin
      bit p_active, p_eol;
      int p_len, p_idx, vprob, period;

      vecs[0] = '{800, 3'b100, 1'b1, 0,   3'b100};
      vecs[1] = '{800, 3'b100, 1'b1, 799, 3'b100};
      vecs[2] = '{10,  3'b111, 1'b1, 9,   3'b111};
      vecs[3] = '{10,  3'b111, 1'b1, 10,  3'b000};
      vecs[4] = '{800, 3'b010, 1'b0, 400, 3'b010};
      vecs[5] = '{1,   3'b011, 1'b1, 0,   3'b011};
      vecs[6] = '{1,   3'b011, 1'b1, 1,   3'b000};
      vecs[7] = '{799, 3'b101, 1'b1, 799, 3'b000};
`ifdef VGA_LB_TEST_PATTERN_EN
      pat150 = 3'b100; pat250 = 3'b110;
`else
      pat150 = 3'b000; pat250 = 3'b000;
`endif

      // Reset
      idle(); rst = 1;
      repeat (3) step();
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_ready", s_ready, 0);
      rst = 0; #1;
      chk("ready_after_rst", s_ready, 1);

      // Table-driven lines: fill, swap, scan, probe
      for (int v = 0; v < 8; v++) begin
         fill(vecs[v].len, vecs[v].color, vecs[v].eol);
         chk($sformatf("vec%0d_ready_wait", v), s_ready, 0);
         scan(1);
         chk($sformatf("vec%0d_probe%0d", v, vecs[v].probe), scan_out[vecs[v].probe], vecs[v].exp);
      end

      // Closing beat coincides with line_start
      fill(9, 3'b110, 0);
      s_valid = 1; s_data = 3'b110; s_eol = 1; line_start = 1;
      step();
      idle();
      scan(0);
      chk("same_cycle_pix0", scan_out[0], 3'b110);
      chk("same_cycle_pix9", scan_out[9], 3'b110);
      chk("same_cycle_pix10", scan_out[10], 3'b000);
      chk("same_cycle_no_underrun", underrun, 0);

      // frame_start mid-fill discards the partial line and drops the concurrent beat
      fill(400, 3'b001, 0);
      s_valid = 1; s_data = 3'b001; frame_start = 1;
      step();
      frame_start = 0; s_valid = 0;
      fill(800, 3'b010, 0);
      chk("frame_ready_wait", s_ready, 0);
      scan(1);
      chk("frame_pix0", scan_out[0], 3'b010);
      chk("frame_pix399", scan_out[399], 3'b010);
      chk("frame_pix799", scan_out[799], 3'b010);

      // Underrun: line_start with nothing filled
      scan(1);
      chk("underrun_set", underrun, 1);
      chk("underrun_pix150", scan_out[150], pat150);
      chk("underrun_pix250", scan_out[250], pat250);
      fill(5, 3'b111, 1);
      scan(1);
      chk("underrun_sticky", underrun, 1);
      chk("after_underrun_pix4", scan_out[4], 3'b111);

      // Reset mid-line while de is high
      fill(800, 3'b111, 1);
      line_start = 1; step(); line_start = 0;
      for (int h = 0; h < 400; h++) begin
         de = 1; h_cnt = 12'(h); step();
      end
      rst = 1; h_cnt = 12'd400;
      step();
      chk("midrst_rgb", {vga_r, vga_g, vga_b}, 0);
      chk("midrst_ready", s_ready, 0);
      chk("midrst_underrun", underrun, 0);
      idle(); rst = 1;
      step();
      rst = 0; #1;
      chk("midrst_ready_after", s_ready, 1);

      // Random traffic against the queue model
      p_active = 0; p_len = 0; p_idx = 0; p_eol = 0;
      for (int ln = 0; ln < 10; ln++) begin
         period = $urandom_range(820, 1056);
         vprob  = $urandom_range(20, 100);
         for (int c = 0; c < period; c++) begin
            line_start  = (c == 0);
            frame_start = ((ln == 4 || ln == 7) && c == 810);
            de          = (c >= 1 && c <= 800);
            h_cnt       = (c == 0) ? 12'd1055 : 12'(c - 1);
            if (!p_active) begin
               p_active = 1; p_idx = 0;
               if ($urandom_range(0, 3) == 0) begin
                  p_len = 800; p_eol = 0;
               end else begin
                  p_len = $urandom_range(1, 800); p_eol = 1;
               end
            end
            s_valid = ($urandom_range(1, 100) <= vprob);
            s_data  = 3'($urandom_range(0, 7));
            s_eol   = p_eol && (p_idx == p_len - 1);
            step();
            if (frame_start) p_active = 0;
            else if (last_acc) begin
               p_idx++;
               if (p_idx == p_len) p_active = 0;
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
